// File: rtl/nco_cos_sin_source_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : nco_cos_sin_source_pkg
//  Brief   : Shared constants and the quarter-wave ROM init function for the
//            packed cos/sin NCO source.
//  Revision: 1.0  initial release
// ============================================================================
package nco_cos_sin_source_pkg;

    localparam real PI = 3.14159265358979323846;

    // Phase value of a quarter turn for a PW-bit accumulator.
    function automatic int quarter_phase(int pw);
        return 1 << (pw - 2);
    endfunction

    // Quarter-wave entry: round(amp*sin(2*pi*(idx+0.5)/2^(lut_addr+2))).
    // The half-step offset makes the table mirror-symmetric, so folding the
    // address with ~a reproduces the second quarter exactly.
    function automatic int rom_entry(int idx, int amp, int lut_addr);
        real ph;
        real full;
        full = real'(1 << (lut_addr + 2));
        ph   = 2.0 * PI * (real'(idx) + 0.5) / full;
        return $rtoi(real'(amp) * $sin(ph) + 0.5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nco_cos_sin_source_if.sv
`default_nettype none
// ============================================================================
//  Module  : nco_cos_sin_source_if
//  Brief   : Packed cos/sin stream (tdata/tvalid/tready) between the NCO and
//            the carrier mixers.
//  Revision: 1.0  initial release
// ============================================================================
interface nco_cos_sin_source_if #(
    parameter int T_WIDTH = 32
);
    logic [T_WIDTH-1:0] NCO_tdata;
    logic               NCO_tvalid;
    logic               NCO_tready;

    modport master (output NCO_tdata, output NCO_tvalid, input  NCO_tready);
    modport slave  (input  NCO_tdata, input  NCO_tvalid, output NCO_tready);
endinterface
`default_nettype wire

// File: rtl/nco_cos_sin_source_rom.sv
`default_nettype none
// ============================================================================
//  Module  : nco_cos_sin_source_rom
//  Brief   : Dual-read quarter-wave sine ROM, one-cycle registered read with
//            clock enable. Contents are elaboration-time constants.
//  Revision: 1.0  initial release
// ============================================================================
module nco_cos_sin_source_rom
    import nco_cos_sin_source_pkg::*;
#(
    parameter int LUT_ADDR = 10,
    parameter int O_WIDTH  = 12
) (
    input  wire logic                 clk,
    input  wire logic                 ce_i,
    input  wire logic [LUT_ADDR-1:0]  addr_a_i,
    input  wire logic [LUT_ADDR-1:0]  addr_b_i,
    output logic      [O_WIDTH-2:0]   data_a_o,
    output logic      [O_WIDTH-2:0]   data_b_o
);
    localparam int DEPTH = 1 << LUT_ADDR;
    localparam int AMP   = (1 << (O_WIDTH - 1)) - 1;

    // Magnitudes only (0..AMP); the sign is applied downstream.
    logic [O_WIDTH-2:0] w_rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam int ENTRY = rom_entry(i, AMP, LUT_ADDR);
        assign w_rom[i] = ENTRY[O_WIDTH-2:0];
    end

    // Registered read on both ports; holds while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (ce_i) begin
            data_a_o <= w_rom[addr_a_i];
            data_b_o <= w_rom[addr_b_i];
        end
    end
endmodule
`default_nettype wire

// File: rtl/nco_cos_sin_source.sv
`default_nettype none
// ============================================================================
//  Module  : nco_cos_sin_source
//  Brief   : Phase accumulator + quarter-wave ROM NCO producing a packed
//            {sin,cos} stream with tready backpressure. 3-stage pipeline.
//  Revision: 1.0  initial release
// ============================================================================
module nco_cos_sin_source
    import nco_cos_sin_source_pkg::*;
#(
    parameter int PHASE_WIDTH = 24,
    parameter int LUT_ADDR    = 10,
    parameter int O_WIDTH     = 12,
    parameter int T_WIDTH     = 32
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    en,
    input  wire logic [PHASE_WIDTH-1:0]  phase_inc,
    input  wire logic                    phase_inc_vld,
    input  wire logic [PHASE_WIDTH-1:0]  phase_ofs,
    nco_cos_sin_source_if.master         nco
);
    localparam int HW  = T_WIDTH / 2;
    localparam int IW  = LUT_ADDR + 2;            // phase bits actually used
    localparam int LOW = PHASE_WIDTH - IW;        // truncated phase bits
    localparam logic [IW-1:0] QUARTER = IW'(quarter_phase(IW));

    if ((HW < O_WIDTH) || (LOW < 1)) begin : g_width_check
        $error("nco_cos_sin_source: T_WIDTH/2 must be >= O_WIDTH and PHASE_WIDTH > LUT_ADDR+2");
    end

    logic [PHASE_WIDTH-1:0] acc_q, inc_q;
    logic                   v1_q, v2_q, tvalid_q;
    logic [IW-1:0]          p1_q;
    logic                   neg_s_q, neg_c_q;
    logic [T_WIDTH-1:0]     tdata_q;

    // Global advance: everything moves unless a presented sample is refused.
    logic w_adv;
    assign w_adv = !(tvalid_q && !nco.NCO_tready);

    // Offset phase; only the ROM index bits are kept (truncation, no dither).
    logic [PHASE_WIDTH-1:0] w_p1_full;
    logic [IW-1:0]          p1_d;
    logic                   w_unused;
    assign w_p1_full = acc_q + phase_ofs;
    assign p1_d      = w_p1_full[PHASE_WIDTH-1 -: IW];
    assign w_unused  = ^w_p1_full[LOW-1:0];

    // Fold: cos phase is a quarter turn ahead; odd quadrants mirror the index.
    logic [IW-1:0]       w_pc;
    logic [LUT_ADDR-1:0] w_addr_s, w_addr_c;
    assign w_pc     = p1_q + QUARTER;
    assign w_addr_s = p1_q[IW-2] ? ~p1_q[LUT_ADDR-1:0] : p1_q[LUT_ADDR-1:0];
    assign w_addr_c = w_pc[IW-2] ? ~w_pc[LUT_ADDR-1:0] : w_pc[LUT_ADDR-1:0];

    logic [O_WIDTH-2:0] w_mag_s, w_mag_c;

    nco_cos_sin_source_rom #(
        .LUT_ADDR (LUT_ADDR),
        .O_WIDTH  (O_WIDTH)
    ) u_rom (
        .clk      (clk),
        .ce_i     (w_adv),
        .addr_a_i (w_addr_s),
        .addr_b_i (w_addr_c),
        .data_a_o (w_mag_s),
        .data_b_o (w_mag_c)
    );

    // Negate in the lower half-cycle and sign-extend into each tdata half.
    logic signed [O_WIDTH-1:0] w_pos_s, w_pos_c, w_sin, w_cos;
    logic        [T_WIDTH-1:0] tdata_d;
    assign w_pos_s = $signed({1'b0, w_mag_s});
    assign w_pos_c = $signed({1'b0, w_mag_c});
    assign w_sin   = neg_s_q ? -w_pos_s : w_pos_s;
    assign w_cos   = neg_c_q ? -w_pos_c : w_pos_c;
    assign tdata_d = {HW'(w_sin), HW'(w_cos)};

    // Frequency word register: loads whenever offered, independent of stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             inc_q <= '0;
        else if (phase_inc_vld) inc_q <= phase_inc;
    end

    // Accumulator and stage 1: inject a new phase on each advancing enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            v1_q  <= 1'b0;
            p1_q  <= '0;
        end else if (w_adv) begin
            v1_q <= en;
            if (en) begin
                acc_q <= acc_q + inc_q;
                p1_q  <= p1_d;
            end
        end
    end

    // Stage 2 control (ROM data itself is registered in the ROM) and stage 3 output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q     <= 1'b0;
            neg_s_q  <= 1'b0;
            neg_c_q  <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else if (w_adv) begin
            v2_q     <= v1_q;
            neg_s_q  <= p1_q[IW-1];
            neg_c_q  <= w_pc[IW-1];
            tvalid_q <= v2_q;
            tdata_q  <= tdata_d;
        end
    end

    assign nco.NCO_tvalid = tvalid_q;
    assign nco.NCO_tdata  = tdata_q;
endmodule
`default_nettype wire
